// File: rtl/branches_pkg.sv
// Shared branch types: comparison encodings follow RISC-V funct3.
// Used by branch_unit and branch_stats.
package branches_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_e;

    localparam int          CNT_W   = 32;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/branch_stats.sv
// Saturating branch / taken-branch event counters.
// Present only in builds with BRANCH_UNIT_STATS_EN defined.
module branch_stats
    import branches_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc_branch,
    input  logic             i_inc_taken,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    // Clear wins over increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (i_clr) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (i_inc_branch && (r_branch_cnt != CNT_MAX))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (i_inc_taken && (r_taken_cnt != CNT_MAX))
                r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign o_branch_cnt = r_branch_cnt;
    assign o_taken_cnt  = r_taken_cnt;

endmodule

// File: rtl/branch_unit.sv
// Conditional-branch comparator with registered decision.
// Optional statistics counters enabled by macro BRANCH_UNIT_STATS_EN.
module branch_unit
    import branches_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             is_branch,
    input  branch_op_e       branch_op,
    output logic             branch_taken,
    output logic             branch_taken_q,
    input  logic             stats_clr,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      taken_cnt
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;
    logic w_cond;
    logic r_taken_q;

    assign w_eq  = (src_a == src_b);
    assign w_lt  = ($signed(src_a) < $signed(src_b));
    assign w_ltu = (src_a < src_b);

    // Encodings 010/011 fall to default and never take.
    always_comb begin
        w_cond = 1'b0;
        case (branch_op)
            BR_EQ:   w_cond = w_eq;
            BR_NE:   w_cond = !w_eq;
            BR_LT:   w_cond = w_lt;
            BR_GE:   w_cond = !w_lt;
            BR_LTU:  w_cond = w_ltu;
            BR_GEU:  w_cond = !w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign branch_taken = is_branch && w_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_taken_q <= 1'b0;
        else
            r_taken_q <= branch_taken;
    end

    assign branch_taken_q = r_taken_q;

`ifdef BRANCH_UNIT_STATS_EN
    branch_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (stats_clr),
        .i_inc_branch (is_branch),
        .i_inc_taken  (branch_taken),
        .o_branch_cnt (branch_cnt),
        .o_taken_cnt  (taken_cnt)
    );
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
    assign branch_cnt = '0;
    assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: per-cycle model compare plus literal vectors.
// Stats expectations follow whether BRANCH_UNIT_STATS_EN is defined.
module tb_branch_unit;
    import branches_pkg::*;

`ifdef BRANCH_UNIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam longint unsigned SAT = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        is_branch;
    branch_op_e  branch_op;
    logic        branch_taken;
    logic        branch_taken_q;
    logic        stats_clr;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_a          (src_a),
        .src_b          (src_b),
        .is_branch      (is_branch),
        .branch_op      (branch_op),
        .branch_taken   (branch_taken),
        .branch_taken_q (branch_taken_q),
        .stats_clr      (stats_clr),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    // Reference decision computed on 64-bit integers
    function automatic bit ref_taken(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic br,
                                     input logic [2:0] op);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        bit     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (int'(op))
            0: r = (ua == ub);
            1: r = (ua != ub);
            4: r = (sa < sb);
            5: r = (sa >= sb);
            6: r = (ua < ub);
            7: r = (ua >= ub);
            default: r = 1'b0;
        endcase
        return br && r;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h t=%0t", name, got, exp, $time);
        end
    endtask

    bit              m_q;
    longint unsigned m_bc;
    longint unsigned m_tc;
    logic            pre = 1'b0;
    bit              m_on = 1'b0;

    always @(posedge clk or negedge rst_n or posedge pre) begin
        if (!rst_n) begin
            m_q  <= 1'b0;
            m_bc <= 0;
            m_tc <= 0;
        end else if (pre) begin
            m_bc <= 64'hFFFF_FFFE;
            m_tc <= 64'hFFFF_FFFE;
        end else begin
            m_q <= ref_taken(src_a, src_b, is_branch, branch_op);
            if (STATS) begin
                if (stats_clr) begin
                    m_bc <= 0;
                    m_tc <= 0;
                end else begin
                    if (is_branch)
                        m_bc <= sat_inc(m_bc);
                    if (ref_taken(src_a, src_b, is_branch, branch_op))
                        m_tc <= sat_inc(m_tc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_taken", {63'b0, branch_taken},
                {63'b0, ref_taken(src_a, src_b, is_branch, branch_op)});
            chk("m_taken_q", {63'b0, branch_taken_q}, {63'b0, m_q});
            chk("m_branch_cnt", {32'b0, branch_cnt}, m_bc);
            chk("m_taken_cnt", {32'b0, taken_cnt}, m_tc);
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic br, input logic [2:0] op,
                         input logic clr);
        src_a     = a;
        src_b     = b;
        is_branch = br;
        branch_op = branch_op_e'(op);
        stats_clr = clr;
    endtask

    task automatic vec(input string name, input logic [31:0] a,
                       input logic [31:0] b, input logic br,
                       input logic [2:0] op, input logic exp);
        @(posedge clk);
        #1;
        drive(a, b, br, op, 1'b0);
        #1;
        chk(name, {63'b0, branch_taken}, {63'b0, exp});
    endtask

    initial begin
        rst_n = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        rst_n = 1'b0;
        m_on  = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_q", {63'b0, branch_taken_q}, 64'd0);
        chk("rst_bcnt", {32'b0, branch_cnt}, 64'd0);
        chk("rst_tcnt", {32'b0, taken_cnt}, 64'd0);
        drive(32'd5, 32'd5, 1'b1, 3'b000, 1'b0);
        #1;
        chk("comb_in_rst", {63'b0, branch_taken}, 64'd1);
        @(posedge clk);
        #1;
        chk("rst_q_hold", {63'b0, branch_taken_q}, 64'd0);
        chk("rst_bcnt_hold", {32'b0, branch_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("disabled", 32'h1, 32'h1, 1'b0, 3'b000, 1'b0);
        vec("eq_same", 32'hA, 32'hA, 1'b1, 3'b000, 1'b1);
        vec("ne_same", 32'hA, 32'hA, 1'b1, 3'b001, 1'b0);
        vec("eq_diff", 32'hA, 32'hB, 1'b1, 3'b000, 1'b0);
        vec("ne_diff", 32'hA, 32'hB, 1'b1, 3'b001, 1'b1);
        vec("ltu_0_max", 32'h0, 32'hFFFF_FFFF, 1'b1, 3'b110, 1'b1);
        vec("lt_0_m1", 32'h0, 32'hFFFF_FFFF, 1'b1, 3'b100, 1'b0);
        vec("geu_max_0", 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b111, 1'b1);
        vec("ge_m1_0", 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b101, 1'b0);
        vec("lt_m1_0", 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b100, 1'b1);
        vec("lt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 1'b1);
        vec("ltu_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b110, 1'b0);
        vec("ge_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b101, 1'b1);
        vec("geu_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b111, 1'b1);
        vec("ltu_eq", 32'h5, 32'h5, 1'b1, 3'b110, 1'b0);
        vec("undef_010", 32'h1, 32'h2, 1'b1, 3'b010, 1'b0);
        vec("undef_011", 32'h1, 32'h1, 1'b1, 3'b011, 1'b0);

        // Toggle taken every cycle; q lags by one edge
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i > 0)
                chk("q_lag", {63'b0, branch_taken_q},
                    {63'b0, ((i - 1) % 2 == 0)});
            if (i % 2 == 0)
                drive(32'h3, 32'h3, 1'b1, 3'b000, 1'b0);
            else
                drive(32'h3, 32'h4, 1'b1, 3'b000, 1'b0);
        end
        drive(32'h3, 32'h3, 1'b1, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        chk("q_before_rst", {63'b0, branch_taken_q}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("q_async_rst", {63'b0, branch_taken_q}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stats: clear, then 5 branches with 3 taken
        @(posedge clk);
        #1;
        drive(32'h1, 32'h1, 1'b1, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("clr_bcnt", {32'b0, branch_cnt}, 64'd0);
                chk("clr_tcnt", {32'b0, taken_cnt}, 64'd0);
            end
            if (i == 2 || i == 4)
                drive(32'h1, 32'h2, 1'b1, 3'b000, 1'b0);
            else
                drive(32'h1, 32'h1, 1'b1, 3'b000, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("bcnt_5", {32'b0, branch_cnt}, STATS ? 64'd5 : 64'd0);
        chk("tcnt_3", {32'b0, taken_cnt}, STATS ? 64'd3 : 64'd0);
        drive(32'h1, 32'h1, 1'b1, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        chk("clr_prio_b", {32'b0, branch_cnt}, 64'd0);
        chk("clr_prio_t", {32'b0, taken_cnt}, 64'd0);
        drive(32'h1, 32'h1, 1'b1, 3'b000, 1'b0);

`ifdef BRANCH_UNIT_STATS_EN
        @(posedge clk);
        #1;
        force dut.u_stats.r_branch_cnt = 32'hFFFF_FFFE;
        force dut.u_stats.r_taken_cnt  = 32'hFFFF_FFFE;
        pre = 1'b1;
        #1;
        release dut.u_stats.r_branch_cnt;
        release dut.u_stats.r_taken_cnt;
        pre = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("sat_bcnt", {32'b0, branch_cnt}, 64'hFFFF_FFFF);
        chk("sat_tcnt", {32'b0, taken_cnt}, 64'hFFFF_FFFF);
`endif

        drive(32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        m_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port src_a  input  WIDTH  first compare operand (rs1).
REQ-005 SHALL have port src_b  input  WIDTH  second compare operand (rs2).
REQ-006 SHALL have port is_branch  input  1  current instruction is a conditional branch.
REQ-007 SHALL have port branch_op  input  branch_op_e (3 bits)  comparison select.
REQ-008 SHALL have port branch_taken  output  1  combinational branch decision.
REQ-009 SHALL have port branch_taken_q  output  1  branch_taken registered one cycle.
REQ-010 SHALL have port stats_clr  input  1  synchronous clear of statistics counters.
REQ-011 SHALL have port branch_cnt  output  32  count of cycles with is_branch=1 (stats build only).
REQ-012 SHALL have port taken_cnt  output  32  count of cycles with branch_taken=1 (stats build only).

Function
REQ-013 branch_taken SHALL be purely combinational from src_a, src_b, is_branch, branch_op, with zero-cycle latency.
REQ-014 branch_taken SHALL be 0 whenever is_branch=0, regardless of other inputs.
REQ-015 With is_branch=1, branch_taken SHALL be: BR_EQ a==b; BR_NE a!=b; BR_LT signed a<b; BR_GE signed a>=b; BR_LTU unsigned a<b; BR_GEU unsigned a>=b.
REQ-016 Signed compares SHALL treat bit WIDTH-1 as two's-complement sign; unsigned compares SHALL treat all bits as magnitude.
REQ-017 Undefined branch_op encodings (010, 011) SHALL yield branch_taken=0.
REQ-018 branch_taken_q SHALL equal branch_taken sampled at the previous rising clk edge.
REQ-019 Per rising edge, branch_cnt SHALL increment by 1 when is_branch=1; taken_cnt SHALL increment by 1 when branch_taken=1.
REQ-020 Counters SHALL saturate at 32'hFFFFFFFF, with no wrap-around.
REQ-021 stats_clr=1 SHALL zero both counters on that edge, taking priority over a simultaneous increment.

Reset
REQ-022 rst_n low SHALL asynchronously force branch_taken_q=0, branch_cnt=0, taken_cnt=0.
REQ-023 branch_taken SHALL remain functional (combinational) during reset.
REQ-024 Reset deassertion SHALL take effect at the next rising clk edge, with no partial counts.

Configuration
REQ-025 Macro BRANCH_UNIT_STATS_EN defined: counters implemented per REQ-019..021.
REQ-026 Macro BRANCH_UNIT_STATS_EN undefined: branch_cnt and taken_cnt SHALL be tied to 0, stats_clr ignored, no counter flops; the port list SHALL be unchanged.

Structure
REQ-027 Package branches_pkg SHALL hold branch_op_e (3-bit enum): BR_EQ=000, BR_NE=001, BR_LT=100, BR_GE=101, BR_LTU=110, BR_GEU=111, matching RISC-V funct3.
REQ-028 Saturating counters SHALL live in one sub-module, branch_stats, instantiated only under BRANCH_UNIT_STATS_EN.

Verification
REQ-029 Disabled branch: is_branch=0, BR_EQ, a=b=1 -> branch_taken=0.
REQ-030 EQ/NE: a=0xA, b=0xA -> EQ 1, NE 0; b=0xB -> EQ 0, NE 1.
REQ-031 Signed vs unsigned: a=0, b=0xFFFFFFFF -> LTU 1, LT 0; a=0xFFFFFFFF, b=0 -> GEU 1, GE 0, LT 1.
REQ-032 Boundary: a=0x80000000, b=0x7FFFFFFF -> LT 1, LTU 0; a=b=0x80000000 -> GE 1, GEU 1; undefined op 010 with is_branch=1 -> branch_taken 0.
REQ-033 Registered output: toggle branch_taken each cycle -> branch_taken_q follows with exactly 1-cycle lag; assert rst_n low mid-cycle -> branch_taken_q=0 immediately.
REQ-034 Stats (BRANCH_UNIT_STATS_EN): 5 branch cycles, 3 taken -> branch_cnt=5, taken_cnt=3; stats_clr together with a branch -> both 0; preload near max -> counters hold 0xFFFFFFFF.
